// File: rtl/stone_plotter.sv
// stone_plotter: draws one Gomoku stone, or erases it back to the board colour, at a board
// cell (row, col). It streams one pixel per cycle to vga_adapter (160x120, 3-bit colour).
//
// Optional feature: define ROUND_STONE_EN to suppress the four corner pixels of the sprite.
// The cycle count does not change.
//
// Ports:
//   clock, resetn         system clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_row, req_col      board cell, each 0..GRID_N-1
//   req_player            0 = black (000), 1 = white (111)
//   req_erase             paint board colour (010); overrides req_player
//   req_err               1-cycle pulse when a request has an out-of-range row or col
//   x, y, colour, plot    pixel stream to vga_adapter
//   done                  1-cycle pulse after the last pixel of a request
module stone_plotter #(
  parameter int unsigned GRID_N   = 15,
  parameter int unsigned CELL     = 8,
  parameter int unsigned STONE    = 6,
  parameter int unsigned ORIGIN_X = 20,
  parameter int unsigned ORIGIN_Y = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_row,
  input  logic [3:0] req_col,
  input  logic       req_player,
  input  logic       req_erase,
  output logic       req_err,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  localparam int unsigned CW = (STONE > 1) ? $clog2(STONE) : 1;
  localparam logic [CW-1:0] LAST = CW'(STONE - 1);
  // Constant part of the sprite base, centring the sprite inside its cell.
  localparam logic [8:0] OFS_X = 9'(ORIGIN_X + (CELL - STONE) / 2);
  localparam logic [8:0] OFS_Y = 9'(ORIGIN_Y + (CELL - STONE) / 2);
  localparam logic [8:0] CELL9 = 9'(CELL);
  localparam logic [4:0] GRID5 = 5'(GRID_N);

  typedef enum logic [1:0] {StIdle, StCalc, StDraw, StFin} state_e;

  state_e        state_q;
  logic [3:0]    row_q;
  logic [3:0]    col_q;
  logic          player_q;
  logic          erase_q;
  logic [7:0]    bx_q;
  logic [6:0]    by_q;
  logic [CW-1:0] cx_q;
  logic [CW-1:0] cy_q;

  assign req_ready = (state_q == StIdle);

`ifdef ROUND_STONE_EN
  logic corner;
  assign corner = ((cx_q == '0) || (cx_q == LAST)) && ((cy_q == '0) || (cy_q == LAST));
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      player_q <= 1'b0;
      erase_q  <= 1'b0;
      bx_q     <= '0;
      by_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      done     <= 1'b0;
      req_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          plot <= 1'b0;
          if (req_valid) begin
            row_q    <= req_row;
            col_q    <= req_col;
            player_q <= req_player;
            erase_q  <= req_erase;
            if (({1'b0, req_row} >= GRID5) || ({1'b0, req_col} >= GRID5)) begin
              req_err <= 1'b1;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          // Base computed at 9 bits, then truncated to the port widths.
          bx_q   <= 8'(OFS_X + 9'(col_q) * CELL9);
          by_q   <= 7'(OFS_Y + 9'(row_q) * CELL9);
          colour <= erase_q ? 3'b010 : (player_q ? 3'b111 : 3'b000);
          cx_q   <= '0;
          cy_q   <= '0;
          state_q <= StDraw;
        end
        StDraw: begin
          x <= bx_q + 8'(cx_q);
          y <= by_q + 7'(cy_q);
`ifdef ROUND_STONE_EN
          plot <= ~corner;
`else
          plot <= 1'b1;
`endif
          if (cx_q == LAST) begin
            cx_q <= '0;
            if (cy_q == LAST) begin
              state_q <= StFin;
            end else begin
              cy_q <= cy_q + 1'b1;
            end
          end else begin
            cx_q <= cx_q + 1'b1;
          end
        end
        StFin: begin
          plot    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
